// File: rtl/frame_buffer_manager.sv
// -----------------------------------------------------------------------------
// frame_buffer_manager
//   Triple-buffer arbiter for a camera -> DDR -> HDMI path. Three DDR "rooms"
//   each hold one frame. The camera-side AXI writer always fills the WRITING
//   room and the HDMI-side AXI reader always scans the READING room. A
//   finished frame parks in READY until the next vsync promotes it. The
//   writer never targets the room being scanned out.
//
//   Optional feature macro: FRAME_FREEZE_EN
//     When defined, adds i_freeze. While the synchronised freeze level is
//     high, vsync events leave the reader room, o_new_frame and o_repeat_cnt
//     untouched. Frame-done handling, including drops, carries on as normal.
//
// Ports
//   clk_100Mhz     in   1   system / AXI clock, rising edge
//   sys_rst_n      in   1   asynchronous active-low reset
//   i_frame_done   in   1   async; rising edge = writer finished its room
//   i_vsync_start  in   1   async; rising edge = reader may switch rooms
//   i_freeze       in   1   async freeze level (FRAME_FREEZE_EN only)
//   o_w_base_addr  out  32  writer frame base address
//   o_r_base_addr  out  32  reader frame base address
//   o_w_room       out  2   writer room index
//   o_r_room       out  2   reader room index
//   o_new_frame    out  1   one-cycle pulse when the reader switches rooms
//   o_frame_cnt    out  16  completed writer frames (saturating)
//   o_drop_cnt     out  16  READY frames discarded unread (saturating)
//   o_repeat_cnt   out  16  vsyncs with no new frame (saturating)
// -----------------------------------------------------------------------------
module frame_buffer_manager #(
  parameter logic [31:0] ROOM0_ADDR  = 32'h0100_0000,
  parameter logic [31:0] ROOM_STRIDE = 32'h0010_0000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk_100Mhz,
  input  logic        sys_rst_n,
  input  logic        i_frame_done,
  input  logic        i_vsync_start,
`ifdef FRAME_FREEZE_EN
  input  logic        i_freeze,
`endif
  output logic [31:0] o_w_base_addr,
  output logic [31:0] o_r_base_addr,
  output logic [1:0]  o_w_room,
  output logic [1:0]  o_r_room,
  output logic        o_new_frame,
  output logic [15:0] o_frame_cnt,
  output logic [15:0] o_drop_cnt,
  output logic [15:0] o_repeat_cnt
);

  typedef enum logic [1:0] {
    ROOM_FREE    = 2'd0,
    ROOM_WRITING = 2'd1,
    ROOM_READY   = 2'd2,
    ROOM_READING = 2'd3
  } room_state_e;

  // ---------------------------------------------------------------------------
  // Input conditioning: SYNC_STAGES-deep synchroniser + one delay flop each
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] fd_sync_q, fd_sync_d;
  logic [SYNC_STAGES-1:0] vs_sync_q, vs_sync_d;
  logic                   fd_dly_q, fd_dly_d;
  logic                   vs_dly_q, vs_dly_d;
  logic                   fd_evt, vs_evt, freeze_act;

`ifdef FRAME_FREEZE_EN
  logic [SYNC_STAGES-1:0] fz_sync_q, fz_sync_d;
`endif

  always_comb begin
    fd_sync_d = {fd_sync_q[SYNC_STAGES-2:0], i_frame_done};
    vs_sync_d = {vs_sync_q[SYNC_STAGES-2:0], i_vsync_start};
    fd_dly_d  = fd_sync_q[SYNC_STAGES-1];
    vs_dly_d  = vs_sync_q[SYNC_STAGES-1];
    fd_evt    = fd_sync_q[SYNC_STAGES-1] & ~fd_dly_q;
    vs_evt    = vs_sync_q[SYNC_STAGES-1] & ~vs_dly_q;
`ifdef FRAME_FREEZE_EN
    fz_sync_d  = {fz_sync_q[SYNC_STAGES-2:0], i_freeze};
    freeze_act = fz_sync_q[SYNC_STAGES-1];
`else
    freeze_act = 1'b0;
`endif
  end

  // ---------------------------------------------------------------------------
  // Room bookkeeping
  // ---------------------------------------------------------------------------
  room_state_e room_q [3];
  room_state_e room_d [3];
  logic [1:0]  w_room_q, w_room_d;
  logic [1:0]  r_room_q, r_room_d;
  logic [31:0] w_base_q, w_base_d;
  logic [31:0] r_base_q, r_base_d;
  logic        new_frame_q, new_frame_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic [15:0] repeat_cnt_q, repeat_cnt_d;
  logic        ready_q_any, ready_d_any, free_found;

  always_comb begin
    room_d       = room_q;
    new_frame_d  = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    drop_cnt_d   = drop_cnt_q;
    repeat_cnt_d = repeat_cnt_q;
    ready_q_any  = 1'b0;
    ready_d_any  = 1'b0;
    free_found   = 1'b0;
    w_room_d     = w_room_q;
    r_room_d     = r_room_q;

    for (int unsigned i = 0; i < 3; i++) begin
      if (room_q[i] == ROOM_READY) ready_q_any = 1'b1;
    end

    // Frame done: writer's room parks as READY, any older READY is dropped.
    if (fd_evt) begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (room_q[i] == ROOM_READY)   room_d[i] = ROOM_FREE;
        if (room_q[i] == ROOM_WRITING) room_d[i] = ROOM_READY;
      end
      if (frame_cnt_q != 16'hFFFF) frame_cnt_d = frame_cnt_q + 16'd1;
      if (ready_q_any && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end

    // Vsync is evaluated against the post-frame-done states, so a
    // simultaneous fd+vs hands the just-finished frame straight to the reader.
    for (int unsigned i = 0; i < 3; i++) begin
      if (room_d[i] == ROOM_READY) ready_d_any = 1'b1;
    end

    if (vs_evt && !freeze_act) begin
      if (ready_d_any) begin
        for (int unsigned i = 0; i < 3; i++) begin
          if (room_d[i] == ROOM_READING)    room_d[i] = ROOM_FREE;
          else if (room_d[i] == ROOM_READY) room_d[i] = ROOM_READING;
        end
        new_frame_d = 1'b1;
      end else if (repeat_cnt_q != 16'hFFFF) begin
        repeat_cnt_d = repeat_cnt_q + 16'd1;
      end
    end

    // Writer claims the lowest FREE room only after both updates.
    if (fd_evt) begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (!free_found && room_d[i] == ROOM_FREE) begin
          room_d[i]  = ROOM_WRITING;
          free_found = 1'b1;
        end
      end
    end

    for (int unsigned i = 0; i < 3; i++) begin
      if (room_d[i] == ROOM_WRITING) w_room_d = 2'(i);
      if (room_d[i] == ROOM_READING) r_room_d = 2'(i);
    end

    w_base_d = ROOM0_ADDR + 32'(w_room_d) * ROOM_STRIDE;
    r_base_d = ROOM0_ADDR + 32'(r_room_d) * ROOM_STRIDE;
  end

  always_ff @(posedge clk_100Mhz or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      fd_sync_q    <= '0;
      vs_sync_q    <= '0;
      fd_dly_q     <= 1'b0;
      vs_dly_q     <= 1'b0;
`ifdef FRAME_FREEZE_EN
      fz_sync_q    <= '0;
`endif
      room_q[0]    <= ROOM_WRITING;
      room_q[1]    <= ROOM_FREE;
      room_q[2]    <= ROOM_READING;
      w_room_q     <= 2'd0;
      r_room_q     <= 2'd2;
      w_base_q     <= ROOM0_ADDR;
      r_base_q     <= ROOM0_ADDR + (ROOM_STRIDE << 1);
      new_frame_q  <= 1'b0;
      frame_cnt_q  <= '0;
      drop_cnt_q   <= '0;
      repeat_cnt_q <= '0;
    end else begin
      fd_sync_q    <= fd_sync_d;
      vs_sync_q    <= vs_sync_d;
      fd_dly_q     <= fd_dly_d;
      vs_dly_q     <= vs_dly_d;
`ifdef FRAME_FREEZE_EN
      fz_sync_q    <= fz_sync_d;
`endif
      room_q       <= room_d;
      w_room_q     <= w_room_d;
      r_room_q     <= r_room_d;
      w_base_q     <= w_base_d;
      r_base_q     <= r_base_d;
      new_frame_q  <= new_frame_d;
      frame_cnt_q  <= frame_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      repeat_cnt_q <= repeat_cnt_d;
    end
  end

  assign o_w_base_addr = w_base_q;
  assign o_r_base_addr = r_base_q;
  assign o_w_room      = w_room_q;
  assign o_r_room      = r_room_q;
  assign o_new_frame   = new_frame_q;
  assign o_frame_cnt   = frame_cnt_q;
  assign o_drop_cnt    = drop_cnt_q;
  assign o_repeat_cnt  = repeat_cnt_q;

  // Writer and reader must never share a room.
  a_rooms_distinct: assert property (
    @(posedge clk_100Mhz) disable iff (!sys_rst_n) w_room_q != r_room_q
  );

endmodule

// File: tb/tb_frame_buffer_manager.sv
// -----------------------------------------------------------------------------
// tb_frame_buffer_manager
//   Directed bench for frame_buffer_manager (default build, freeze absent).
//   Expected values are hand-derived from the room-state rules.
// -----------------------------------------------------------------------------
module tb_frame_buffer_manager;

  logic        clk_100Mhz;
  logic        sys_rst_n;
  logic        i_frame_done;
  logic        i_vsync_start;
  logic [31:0] o_w_base_addr;
  logic [31:0] o_r_base_addr;
  logic [1:0]  o_w_room;
  logic [1:0]  o_r_room;
  logic        o_new_frame;
  logic [15:0] o_frame_cnt;
  logic [15:0] o_drop_cnt;
  logic [15:0] o_repeat_cnt;

  int unsigned tests_run    = 0;
  int unsigned tests_failed = 0;
  int unsigned nf_pulses    = 0;
  int unsigned nf_base;

  frame_buffer_manager #(
    .ROOM0_ADDR  (32'h0100_0000),
    .ROOM_STRIDE (32'h0010_0000),
    .SYNC_STAGES (2)
  ) dut (
    .clk_100Mhz    (clk_100Mhz),
    .sys_rst_n     (sys_rst_n),
    .i_frame_done  (i_frame_done),
    .i_vsync_start (i_vsync_start),
    .o_w_base_addr (o_w_base_addr),
    .o_r_base_addr (o_r_base_addr),
    .o_w_room      (o_w_room),
    .o_r_room      (o_r_room),
    .o_new_frame   (o_new_frame),
    .o_frame_cnt   (o_frame_cnt),
    .o_drop_cnt    (o_drop_cnt),
    .o_repeat_cnt  (o_repeat_cnt)
  );

  initial clk_100Mhz = 1'b0;
  always #5 clk_100Mhz = ~clk_100Mhz;

  always @(negedge clk_100Mhz) begin
    if (o_new_frame) nf_pulses++;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic wait_cycles(input int unsigned n);
    repeat (n) @(negedge clk_100Mhz);
  endtask

  task automatic do_reset();
    @(negedge clk_100Mhz);
    sys_rst_n     = 1'b0;
    i_frame_done  = 1'b0;
    i_vsync_start = 1'b0;
    wait_cycles(3);
    sys_rst_n = 1'b1;
    wait_cycles(2);
  endtask

  // Drive a 4-cycle high pulse (one 25 MHz period) then settle.
  task automatic pulse_fd();
    @(negedge clk_100Mhz);
    i_frame_done = 1'b1;
    wait_cycles(4);
    i_frame_done = 1'b0;
    wait_cycles(6);
  endtask

  task automatic pulse_vs();
    @(negedge clk_100Mhz);
    i_vsync_start = 1'b1;
    wait_cycles(4);
    i_vsync_start = 1'b0;
    wait_cycles(6);
  endtask

  initial begin
    sys_rst_n     = 1'b0;
    i_frame_done  = 1'b0;
    i_vsync_start = 1'b0;
    wait_cycles(2);
    #1 check_eq("async_reset_w_room", 32'(o_w_room), 32'd0);
    sys_rst_n = 1'b1;
    wait_cycles(3);

    // Reset then idle
    check_eq("rst_w_room",  32'(o_w_room), 32'd0);
    check_eq("rst_r_room",  32'(o_r_room), 32'd2);
    check_eq("rst_w_base",  o_w_base_addr, 32'h0100_0000);
    check_eq("rst_r_base",  o_r_base_addr, 32'h0120_0000);
    check_eq("rst_frame",   32'(o_frame_cnt), 32'd0);
    check_eq("rst_drop",    32'(o_drop_cnt), 32'd0);
    check_eq("rst_repeat",  32'(o_repeat_cnt), 32'd0);
    check_eq("rst_newfrm",  32'(o_new_frame), 32'd0);

    // Single fd: visible on the 3rd edge after first sample, not the 2nd
    @(negedge clk_100Mhz);
    i_frame_done = 1'b1;
    @(posedge clk_100Mhz);
    @(posedge clk_100Mhz);
    #1 check_eq("fd_lat_early_w_room", 32'(o_w_room), 32'd0);
    @(posedge clk_100Mhz);
    #1 check_eq("fd_lat_w_room", 32'(o_w_room), 32'd1);
    check_eq("fd_lat_frame", 32'(o_frame_cnt), 32'd1);
    check_eq("fd_w_base", o_w_base_addr, 32'h0110_0000);
    @(negedge clk_100Mhz);
    i_frame_done = 1'b0;
    wait_cycles(100);
    nf_base = nf_pulses;
    pulse_vs();
    check_eq("vs_r_room", 32'(o_r_room), 32'd0);
    check_eq("vs_r_base", o_r_base_addr, 32'h0100_0000);
    check_eq("vs_nf_pulses", nf_pulses - nf_base, 32'd1);
    check_eq("vs_repeat", 32'(o_repeat_cnt), 32'd0);

    // Three fd, no vs
    do_reset();
    pulse_fd();
    check_eq("fd3_a_w_room", 32'(o_w_room), 32'd1);
    pulse_fd();
    check_eq("fd3_b_w_room", 32'(o_w_room), 32'd0);
    check_eq("fd3_b_r_room", 32'(o_r_room), 32'd2);
    pulse_fd();
    check_eq("fd3_c_w_room", 32'(o_w_room), 32'd1);
    check_eq("fd3_r_room", 32'(o_r_room), 32'd2);
    check_eq("fd3_drop", 32'(o_drop_cnt), 32'd2);
    check_eq("fd3_frame", 32'(o_frame_cnt), 32'd3);

    // Two vs, no fd
    do_reset();
    nf_base = nf_pulses;
    pulse_vs();
    pulse_vs();
    check_eq("rep_cnt", 32'(o_repeat_cnt), 32'd2);
    check_eq("rep_r_room", 32'(o_r_room), 32'd2);
    check_eq("rep_nf_pulses", nf_pulses - nf_base, 32'd0);

    // Simultaneous fd and vs
    do_reset();
    nf_base = nf_pulses;
    @(negedge clk_100Mhz);
    i_frame_done  = 1'b1;
    i_vsync_start = 1'b1;
    wait_cycles(4);
    i_frame_done  = 1'b0;
    i_vsync_start = 1'b0;
    wait_cycles(6);
    check_eq("sim_r_room", 32'(o_r_room), 32'd0);
    check_eq("sim_w_room", 32'(o_w_room), 32'd1);
    check_eq("sim_w_base", o_w_base_addr, 32'h0110_0000);
    check_eq("sim_r_base", o_r_base_addr, 32'h0100_0000);
    check_eq("sim_nf_pulses", nf_pulses - nf_base, 32'd1);
    check_eq("sim_repeat", 32'(o_repeat_cnt), 32'd0);
    // Room 2 must be FREE: next fd parks room 1 and the writer takes room 2
    pulse_fd();
    check_eq("sim_next_w_room", 32'(o_w_room), 32'd2);
    check_eq("sim_next_drop", 32'(o_drop_cnt), 32'd0);

    // Held fd level counts once; reset mid-run returns to reset state
    do_reset();
    @(negedge clk_100Mhz);
    i_frame_done = 1'b1;
    wait_cycles(10000);
    check_eq("hold_frame", 32'(o_frame_cnt), 32'd1);
    check_eq("hold_w_room", 32'(o_w_room), 32'd1);
    sys_rst_n = 1'b0;
    #1;
    check_eq("midrst_w_room", 32'(o_w_room), 32'd0);
    check_eq("midrst_frame", 32'(o_frame_cnt), 32'd0);
    check_eq("midrst_w_base", o_w_base_addr, 32'h0100_0000);
    i_frame_done = 1'b0;
    wait_cycles(2);
    sys_rst_n = 1'b1;
    wait_cycles(5);
    check_eq("postrst_w_room", 32'(o_w_room), 32'd0);
    check_eq("postrst_r_room", 32'(o_r_room), 32'd2);
    check_eq("postrst_frame", 32'(o_frame_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
